core_pipe_stage: RTL

//  Parametrised IF->ID style pipeline register with valid/ready handshake, flush and optional
//  2-entry skid buffer. Carries {inst_addr, inst} pairs in order; an empty stage presents NOP.

---
 rtl/core_pipe_stage_if.sv | 14 +
 rtl/core_pipe_stage.sv | 127 ++++++++++++
 2 files changed

// File: rtl/core_pipe_stage_if.sv
// Valid/ready channel carrying one {addr, inst} pair.
// The producer uses the master modport and the consumer uses the slave modport.
interface core_pipe_stage_if #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32
);
  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [INST_W-1:0] inst;

  modport master (output valid, output addr, output inst, input ready);
  modport slave  (input valid, input addr, input inst, output ready);
endinterface

// File: rtl/core_pipe_stage.sv
// Pipeline register between fetch and decode, with flush and an optional 2-entry skid buffer.
// When the stage is empty it presents NOP, and out_addr keeps the last address it presented.
module core_pipe_stage #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RST_ADDR = '0,
  parameter logic [INST_W-1:0] NOP      = INST_W'(32'h0000_0013),
  parameter bit                SKID     = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  core_pipe_stage_if.slave    up,
  core_pipe_stage_if.master   dn,
  output logic [1:0]          occupancy
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  logic              accept;
  logic              issue;
  logic              in_ready_w;
  logic              out_valid_w;
  logic              load_in;
  logic              load_from_skid;
  logic              load_skid;
  logic [ADDR_W-1:0] main_addr_reg;
  logic [INST_W-1:0] main_inst_reg;
  logic [ADDR_W-1:0] skid_addr_reg;
  logic [INST_W-1:0] skid_inst_reg;

  assign accept   = up.valid & in_ready_w;
  assign issue    = out_valid_w & dn.ready;
  assign up.ready = in_ready_w;
  assign dn.valid = out_valid_w;
  assign dn.addr  = main_addr_reg;
  assign dn.inst  = out_valid_w ? main_inst_reg : NOP;

  generate
    if (SKID) begin : gen_skid
      state_t state_reg;
      state_t state_next;

      always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_EMPTY;
        else     state_reg <= state_next;
      end

      always_comb begin
        state_next     = state_reg;
        load_in        = 1'b0;
        load_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state_reg)
          ST_EMPTY: if (accept) begin
            state_next = ST_ONE;
            load_in    = 1'b1;
          end
          ST_ONE: begin
            if (accept && issue) begin
              load_in = 1'b1;
            end else if (accept) begin
              state_next = ST_TWO;
              load_skid  = 1'b1;
            end else if (issue) begin
              state_next = ST_EMPTY;
            end
          end
          ST_TWO: if (issue) begin
            state_next     = ST_ONE;
            load_from_skid = 1'b1;
          end
          default: state_next = ST_EMPTY;
        endcase
        // Flush drops everything, including an entry accepted in the same cycle.
        if (flush) begin
          state_next     = ST_EMPTY;
          load_in        = 1'b0;
          load_from_skid = 1'b0;
          load_skid      = 1'b0;
        end
      end

      // in_ready comes only from the state flops, so out_ready has no combinational path to it.
      assign out_valid_w = (state_reg != ST_EMPTY);
      assign in_ready_w  = (state_reg != ST_TWO);
      assign occupancy   = {state_reg == ST_TWO, state_reg == ST_ONE};
    end else begin : gen_single
      logic valid_reg;

      always_ff @(posedge clk) begin
        if (rst)         valid_reg <= 1'b0;
        else if (flush)  valid_reg <= 1'b0;
        else if (accept) valid_reg <= 1'b1;
        else if (issue)  valid_reg <= 1'b0;
      end

      assign in_ready_w     = ~valid_reg | dn.ready;
      assign out_valid_w    = valid_reg;
      assign load_in        = accept & ~flush;
      assign load_from_skid = 1'b0;
      assign load_skid      = 1'b0;
      assign occupancy      = {1'b0, valid_reg};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      main_addr_reg <= RST_ADDR;
      main_inst_reg <= NOP;
    end else if (load_in) begin
      main_addr_reg <= up.addr;
      main_inst_reg <= up.inst;
    end else if (load_from_skid) begin
      main_addr_reg <= skid_addr_reg;
      main_inst_reg <= skid_inst_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (load_skid) begin
      skid_addr_reg <= up.addr;
      skid_inst_reg <= up.inst;
    end
  end

endmodule
